// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO family: sizing helper, read modes
// and a parameter-legality check that FIFO variants can call from their benches.
package fifo_pkg;

    localparam int FIFO_MODE_REG  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    task automatic check_fifo_params(
        input  int width,
        input  int depth,
        input  int af_thresh,
        input  int ae_thresh,
        input  int fwft,
        output bit ok
    );
        ok = (width >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
             (af_thresh >= 1) && (af_thresh <= depth) &&
             (ae_thresh >= 0) && (ae_thresh <= depth - 1) &&
             ((fwft == FIFO_MODE_REG) || (fwft == FIFO_MODE_FWFT));
    endtask

endpackage

// File: rtl/fifo_ram.sv
// WIDTH x DEPTH register array: one synchronous write port, one asynchronous read port.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with programmable almost flags, fill level, sticky error
// flags and a selectable registered or first-word-fall-through read port.
module sync_fifo_ext
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = FIFO_MODE_REG
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic                     full_o,
    output logic                     almost_full_o,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic                     almost_empty_o,
    output logic [clog2(DEPTH):0]    level_o,
    output logic                     overflow_o,
    output logic                     underflow_o,
    input  logic                     clr_err_i
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_acc;
    logic             rd_acc;
    logic [WIDTH-1:0] rd_data;

    assign full_o         = (count == CW'(DEPTH));
    assign empty_o        = (count == '0);
    assign almost_full_o  = (count >= CW'(AF_THRESH));
    assign almost_empty_o = (count <= CW'(AE_THRESH));
    assign level_o        = count;

    // Full implies non-empty, so a write while full is safe whenever a read is also requested.
    assign rd_acc = rd_en_i && !empty_o;
    assign wr_acc = wr_en_i && (!full_o || rd_en_i);

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_i),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A new error in the same cycle as a clear must stay visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= (overflow_o  && !clr_err_i) || (wr_en_i && !wr_acc);
            underflow_o <= (underflow_o && !clr_err_i) || (rd_en_i && empty_o);
        end
    end

    generate
        if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
            assign data_o = empty_o ? '0 : rd_data;
        end else begin : g_reg
            logic [WIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= rd_data;
                end
            end

            assign data_o = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: one registered-read and one FWFT instance against a
// queue-based reference model, plus directed literal expectations.
module tb_sync_fifo_ext;

    logic       clk;
    logic       rst_n;
    logic       wr_en   [2];
    logic [7:0] din     [2];
    logic       rd_en   [2];
    logic       clr     [2];
    logic       full    [2];
    logic       afull   [2];
    logic [7:0] dout    [2];
    logic       empty   [2];
    logic       aempty  [2];
    logic [3:0] level   [2];
    logic       ovf     [2];
    logic       udf     [2];

    int checks   = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_ext #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)) u_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en_i        (wr_en[0]),
        .data_i         (din[0]),
        .full_o         (full[0]),
        .almost_full_o  (afull[0]),
        .rd_en_i        (rd_en[0]),
        .data_o         (dout[0]),
        .empty_o        (empty[0]),
        .almost_empty_o (aempty[0]),
        .level_o        (level[0]),
        .overflow_o     (ovf[0]),
        .underflow_o    (udf[0]),
        .clr_err_i      (clr[0])
    );

    sync_fifo_ext #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)) u_fwft (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en_i        (wr_en[1]),
        .data_i         (din[1]),
        .full_o         (full[1]),
        .almost_full_o  (afull[1]),
        .rd_en_i        (rd_en[1]),
        .data_o         (dout[1]),
        .empty_o        (empty[1]),
        .almost_empty_o (aempty[1]),
        .level_o        (level[1]),
        .overflow_o     (ovf[1]),
        .underflow_o    (udf[1]),
        .clr_err_i      (clr[1])
    );

    // Reference model: contents as a queue, sticky flags, registered read data.
    logic [7:0] mq    [2][$];
    logic       m_ovf [2];
    logic       m_udf [2];
    logic [7:0] m_dreg[2];

    always @(posedge clk or negedge rst_n) begin
        int  n;
        bit  rok;
        bit  wok;
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                mq[k].delete();
                m_ovf[k]  = 1'b0;
                m_udf[k]  = 1'b0;
                m_dreg[k] = 8'h00;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                n   = mq[k].size();
                rok = rd_en[k] && (n > 0);
                wok = wr_en[k] && ((n < 8) || rd_en[k]);
                m_ovf[k] = (m_ovf[k] && !clr[k]) || (wr_en[k] && !wok);
                m_udf[k] = (m_udf[k] && !clr[k]) || (rd_en[k] && (n == 0));
                if (rok) begin
                    m_dreg[k] = mq[k].pop_front();
                end
                if (wok) begin
                    mq[k].push_back(din[k]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int         n;
        logic [7:0] ed;
        for (int k = 0; k < 2; k++) begin
            n = mq[k].size();
            if (k == 0) ed = m_dreg[0];
            else        ed = (n == 0) ? 8'h00 : mq[1][0];
            chk($sformatf("level%0d", k),  32'(level[k]),  32'(n));
            chk($sformatf("full%0d", k),   32'(full[k]),   32'(n == 8));
            chk($sformatf("empty%0d", k),  32'(empty[k]),  32'(n == 0));
            chk($sformatf("afull%0d", k),  32'(afull[k]),  32'(n >= 6));
            chk($sformatf("aempty%0d", k), 32'(aempty[k]), 32'(n <= 1));
            chk($sformatf("ovf%0d", k),    32'(ovf[k]),    32'(m_ovf[k]));
            chk($sformatf("udf%0d", k),    32'(udf[k]),    32'(m_udf[k]));
            chk($sformatf("dout%0d", k),   32'(dout[k]),   32'(ed));
        end
    end

    task automatic op(input int k, input bit w, input logic [7:0] d, input bit r, input bit c);
        wr_en[k] = w;
        din[k]   = d;
        rd_en[k] = r;
        clr[k]   = c;
        @(negedge clk);
        wr_en[k] = 1'b0;
        rd_en[k] = 1'b0;
        clr[k]   = 1'b0;
    endtask

    task automatic chk_reset_outputs(input int k, input string tag);
        chk({tag, "_empty"},  32'(empty[k]),  32'd1);
        chk({tag, "_aempty"}, 32'(aempty[k]), 32'd1);
        chk({tag, "_full"},   32'(full[k]),   32'd0);
        chk({tag, "_afull"},  32'(afull[k]),  32'd0);
        chk({tag, "_level"},  32'(level[k]),  32'd0);
        chk({tag, "_dout"},   32'(dout[k]),   32'd0);
        chk({tag, "_ovf"},    32'(ovf[k]),    32'd0);
        chk({tag, "_udf"},    32'(udf[k]),    32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            wr_en[k] = 1'b0;
            din[k]   = 8'h00;
            rd_en[k] = 1'b0;
            clr[k]   = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs(0, "rst_reg");
        chk_reset_outputs(1, "rst_fwft");
        rst_n = 1'b1;
        @(negedge clk);

        // Fill and overfill the registered-read FIFO
        for (int i = 1; i <= 8; i++) begin
            op(0, 1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_level", 32'(level[0]), 32'(i));
            chk("fill_afull", 32'(afull[0]), 32'(i >= 6));
            chk("fill_full",  32'(full[0]),  32'(i == 8));
        end
        op(0, 1'b1, 8'h09, 1'b0, 1'b0);
        chk("overfill_level", 32'(level[0]), 32'd8);
        chk("overfill_ovf",   32'(ovf[0]),   32'd1);
        op(0, 1'b1, 8'h0A, 1'b0, 1'b1);
        chk("set_beats_clear", 32'(ovf[0]), 32'd1);
        op(0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", 32'(ovf[0]), 32'd0);

        for (int i = 1; i <= 8; i++) begin
            op(0, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("drain_data", 32'(dout[0]), 32'(i));
        end
        chk("drain_empty", 32'(empty[0]), 32'd1);

        for (int i = 0; i < 12; i++) begin
            op(0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
            op(0, 1'b0, 8'h00, 1'b1, 1'b0);
            chk("wrap_data", 32'(dout[0]), 32'(8'h30 + i));
        end

        op(0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_read_udf",  32'(udf[0]),  32'd1);
        chk("empty_read_hold", 32'(dout[0]), 32'h3B);
        op(0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_udf", 32'(udf[0]), 32'd0);

        // Simultaneous write and read while full
        for (int i = 0; i < 8; i++) op(0, 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        op(0, 1'b1, 8'hAA, 1'b1, 1'b0);
        chk("full_rw_level", 32'(level[0]), 32'd8);
        chk("full_rw_data",  32'(dout[0]),  32'h40);
        chk("full_rw_ovf",   32'(ovf[0]),   32'd0);
        for (int i = 1; i < 8; i++) op(0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_rw_pre_last", 32'(dout[0]), 32'h47);
        op(0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("full_rw_last", 32'(dout[0]), 32'hAA);

        // Simultaneous write and read while empty
        op(0, 1'b1, 8'h55, 1'b1, 1'b0);
        chk("empty_rw_level", 32'(level[0]), 32'd1);
        chk("empty_rw_udf",   32'(udf[0]),   32'd1);
        chk("empty_rw_hold",  32'(dout[0]),  32'hAA);
        op(0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("empty_rw_data", 32'(dout[0]), 32'h55);
        chk("empty_rw_clr",  32'(udf[0]),  32'd0);

        // First-word-fall-through instance
        op(1, 1'b1, 8'h11, 1'b0, 1'b0);
        chk("fwft_first", 32'(dout[1]), 32'h11);
        op(1, 1'b1, 8'h22, 1'b0, 1'b0);
        chk("fwft_hold", 32'(dout[1]), 32'h11);
        op(1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_next", 32'(dout[1]), 32'h22);
        op(1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_empty_data", 32'(dout[1]), 32'h00);
        chk("fwft_empty",      32'(empty[1]), 32'd1);
        op(1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("fwft_udf", 32'(udf[1]), 32'd1);

        // Asynchronous reset in the middle of operation
        for (int i = 0; i < 5; i++) op(0, 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        op(0, 1'b0, 8'h00, 1'b1, 1'b0);
        op(0, 1'b1, 8'h65, 1'b0, 1'b0);
        chk("pre_reset_level", 32'(level[0]), 32'd5);
        chk("pre_reset_dout",  32'(dout[0]),  32'h60);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0, "mid_rst_reg");
        chk_reset_outputs(1, "mid_rst_fwft");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(0, 1'b1, 8'h77, 1'b0, 1'b0);
        op(1, 1'b1, 8'h78, 1'b0, 1'b0);
        chk("post_rst_fwft", 32'(dout[1]), 32'h78);
        op(0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("post_rst_data",  32'(dout[0]),  32'h77);
        chk("post_rst_level", 32'(level[0]), 32'd0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
